// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes and the divider state encoding.
package alu_pkg;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor when it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    dvs_ext = {2'b00, divisor_i};
    if (shifted >= dvs_ext) begin
      rem_o = (WIDTH+1)'(shifted - dvs_ext);
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = (WIDTH+1)'(shifted);
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// Sequential DIVU unit writing quotient to Lo and remainder to Hi, read via MFHI/MFLO.
// Define HILO_DIVIDER_SIGNED_EN to also accept signed DIV (function code 26).
module hilo_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             dbz
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic [5:0]       sig_prev_q, sig_prev_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             start_u;
  logic             start_s;
  logic [WIDTH-1:0] rem_lo;

`ifdef HILO_DIVIDER_SIGNED_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
      sig_prev_q <= '0;
`ifdef HILO_DIVIDER_SIGNED_EN
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      dbz_q      <= dbz_d;
      sig_prev_q <= sig_prev_d;
`ifdef HILO_DIVIDER_SIGNED_EN
      sa_q       <= sa_d;
      sb_q       <= sb_d;
`endif
    end
  end

  // Next-state and datapath; starts are edge-qualified against last cycle's Signal.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    count_d    = count_q;
    busy_d     = busy_q;
    dbz_d      = dbz_q;
    sig_prev_d = Signal;
    rem_lo     = rem_q[WIDTH-1:0];
    start_u    = (Signal == FN_DIVU) && (sig_prev_q != FN_DIVU);
`ifdef HILO_DIVIDER_SIGNED_EN
    start_s    = (Signal == FN_DIV) && (sig_prev_q != FN_DIV);
    sa_d       = sa_q;
    sb_d       = sb_q;
`else
    start_s    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start_u || start_s) begin
          quo_d   = dataA;
          dvs_d   = dataB;
          rem_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef HILO_DIVIDER_SIGNED_EN
          sa_d = start_s && dataA[WIDTH-1];
          sb_d = start_s && dataB[WIDTH-1];
          if (sa_d) quo_d = -dataA;
          if (sb_d) dvs_d = -dataB;
`endif
        end
      end
      RUN: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH-1)) state_d = DONE;
      end
      DONE: begin
        hi_d    = rem_lo;
        lo_d    = quo_q;
        dbz_d   = (dvs_q == '0);
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef HILO_DIVIDER_SIGNED_EN
        // Divide by zero keeps the all-ones quotient; remainder follows the dividend sign.
        if ((sa_q ^ sb_q) && (dvs_q != '0)) lo_d = -quo_q;
        if (sa_q) hi_d = -rem_lo;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (Signal)
      FN_MFHI: Output = hi_q;
      FN_MFLO: Output = lo_q;
      default: Output = '0;
    endcase
  end

  assign busy = busy_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed self-checking bench for hilo_divider; signed checks follow HILO_DIVIDER_SIGNED_EN.
module tb_hilo_divider;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] Output;
  logic        busy;
  logic        dbz;

  int vectors = 0;
  int errors  = 0;

  hilo_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .dataA (dataA),
    .dataB (dataB),
    .Signal(Signal),
    .Output(Output),
    .busy  (busy),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    logic [5:0] saved;
    saved  = Signal;
    Signal = 6'd16;
    #1 hi = Output;
    Signal = 6'd18;
    #1 lo = Output;
    Signal = saved;
    #1;
  endtask

  // Launch one operation holding Signal for 'hold' cycles; report busy cycles and pulses.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int cycles, output int pulses);
    int   win;
    logic pb;
    Signal = 6'd0;
    tick();
    Signal = op;
    dataA  = a;
    dataB  = b;
    tick();
    cycles = 0;
    pulses = 0;
    pb     = 1'b0;
    win    = ((hold > 34) ? hold : 34) + 4;
    for (int k = 0; k < win; k++) begin
      if (busy) cycles++;
      if (busy && !pb) pulses++;
      pb = busy;
      if (k + 1 >= hold) Signal = 6'd0;
      tick();
    end
    Signal = 6'd0;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b want 0", dbz); end
    vectors++; if (Output !== 32'd0) begin errors++; $display("FAIL reset_output got %0h want 0", Output); end
    read_hilo(hi, lo);
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %0h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %0h want 0", lo); end
  endtask

  task automatic test_basic();
    logic [31:0] hi, lo;
    int cyc, pul;
    run_op(6'd27, 32'd100, 32'd7, 33, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (cyc !== 33) begin errors++; $display("FAIL basic_busy_cycles got %0d want 33", cyc); end
    vectors++; if (hi !== 32'd2) begin errors++; $display("FAIL basic_hi got %0d want 2", hi); end
    vectors++; if (lo !== 32'd14) begin errors++; $display("FAIL basic_lo got %0d want 14", lo); end
    vectors++; if (dbz !== 1'b0) begin errors++; $display("FAIL basic_dbz got %0b want 0", dbz); end
  endtask

  task automatic test_large();
    logic [31:0] hi, lo;
    int cyc, pul;
    run_op(6'd27, 32'hFFFF_FFFF, 32'd1, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL large_lo got %0h want ffffffff", lo); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL large_hi got %0h want 0", hi); end
    run_op(6'd27, 32'd3, 32'd10, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL small_lo got %0d want 0", lo); end
    vectors++; if (hi !== 32'd3) begin errors++; $display("FAIL small_hi got %0d want 3", hi); end
    vectors++; if (cyc !== 33) begin errors++; $display("FAIL small_busy_cycles got %0d want 33", cyc); end
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    int cyc, pul;
    run_op(6'd27, 32'd5, 32'd0, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo got %0h want ffffffff", lo); end
    vectors++; if (hi !== 32'd5) begin errors++; $display("FAIL dbz_hi got %0d want 5", hi); end
    vectors++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got %0b want 1", dbz); end
    run_op(6'd27, 32'd9, 32'd3, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (lo !== 32'd3) begin errors++; $display("FAIL after_dbz_lo got %0d want 3", lo); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL after_dbz_hi got %0d want 0", hi); end
    vectors++; if (dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear got %0b want 0", dbz); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    int cyc, pul;
    Signal = 6'd0;
    tick();
    Signal = 6'd27;
    dataA  = 32'd1000;
    dataB  = 32'd3;
    tick();
    Signal = 6'd0;
    for (int k = 1; k < 10; k++) tick();
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %0b want 1", busy); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got %0b want 0", busy); end
    read_hilo(hi, lo);
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL mid_hi got %0h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL mid_lo got %0h want 0", lo); end
    run_op(6'd27, 32'd1000, 32'd3, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (lo !== 32'd333) begin errors++; $display("FAIL redo_lo got %0d want 333", lo); end
    vectors++; if (hi !== 32'd1) begin errors++; $display("FAIL redo_hi got %0d want 1", hi); end
  endtask

  // Prior Hi is 1 from the 1000/3 division.
  task automatic test_back_to_back();
    logic [31:0] hi, lo, mid_hi;
    int   cyc, pul;
    logic pb;
    Signal = 6'd0;
    tick();
    Signal = 6'd27;
    dataA  = 32'd81;
    dataB  = 32'd9;
    tick();
    cyc    = 0;
    pul    = 0;
    pb     = 1'b0;
    mid_hi = 32'hDEAD_BEEF;
    for (int k = 0; k < 80; k++) begin
      if (busy) cyc++;
      if (busy && !pb) pul++;
      pb = busy;
      if (k == 4) dataA = 32'd50;
      if (k == 10) begin
        Signal = 6'd16;
        #1 mid_hi = Output;
        Signal = 6'd27;
      end
      tick();
    end
    Signal = 6'd0;
    read_hilo(hi, lo);
    vectors++; if (mid_hi !== 32'd1) begin errors++; $display("FAIL busy_mfhi got %0d want 1", mid_hi); end
    vectors++; if (pul !== 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pul); end
    vectors++; if (cyc !== 33) begin errors++; $display("FAIL held_busy_cycles got %0d want 33", cyc); end
    vectors++; if (lo !== 32'd9) begin errors++; $display("FAIL held_lo got %0d want 9", lo); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL held_hi got %0d want 0", hi); end
  endtask

  task automatic test_signed();
    logic [31:0] hi, lo;
    int cyc, pul;
`ifdef HILO_DIVIDER_SIGNED_EN
    run_op(6'd26, 32'hFFFF_FFF9, 32'd2, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_lo got %0h want fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_hi got %0h want ffffffff", hi); end
    run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL sdiv_ovf_lo got %0h want 80000000", lo); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL sdiv_ovf_hi got %0h want 0", hi); end
    run_op(6'd26, 32'hFFFF_FFFB, 32'd0, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_dbz_lo got %0h want ffffffff", lo); end
    vectors++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL sdiv_dbz_hi got %0h want fffffffb", hi); end
`else
    // Hi/Lo still hold 0/9 from the held-signal test.
    run_op(6'd26, 32'd100, 32'd7, 1, cyc, pul);
    read_hilo(hi, lo);
    vectors++; if (cyc !== 0) begin errors++; $display("FAIL div26_busy got %0d want 0", cyc); end
    vectors++; if (lo !== 32'd9) begin errors++; $display("FAIL div26_lo got %0d want 9", lo); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL div26_hi got %0d want 0", hi); end
`endif
  endtask

  initial begin
    reset  = 1'b1;
    dataA  = 32'd0;
    dataB  = 32'd0;
    Signal = 6'd0;
    tick();
    test_reset();
    test_basic();
    test_large();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    test_signed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
- Sequential shift-subtract (restoring) divider, one bit per cycle, for the ALU datapath.
- Complements the MULTU multiplier in the same ALU: it executes DIVU and writes quotient to Lo and remainder to Hi.
- Hi/Lo are read back through the existing MFHI/MFLO function codes.
- Uses the same dataA/dataB/Signal/Output interface and function-code decoding as the rest of the ALU.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low: state is cleared on a rising clk edge while reset==0.
- dataA  input  WIDTH  dividend.
- dataB  input  WIDTH  divisor.
- Signal  input  6  function code: DIVU=27, MFHI=16, MFLO=18; all other codes are ignored.
- Output  output  WIDTH  Hi when Signal==16, Lo when Signal==18, otherwise 0; combinational from registers.
- busy  output  1  high while a division is in progress.
- dbz  output  1  high when the last completed division had divisor==0; updated together with Hi/Lo.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; Hi=0, Lo=0, count=0, busy=0, dbz=0.
  - Signal history register cleared to 0.
  - Output is 0 unless Signal selects Hi/Lo, which read 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, count runs 0..WIDTH-1.
  - DONE: busy=1, lasts one cycle.
- Start condition: state==IDLE && Signal==27 && previous-cycle Signal!=27.
  - Start is edge-qualified, so holding DIVU for many cycles gives exactly one division.
  - A new division needs Signal to leave 27 and return.
- Start cycle t0:
  - Latch dataA into the quotient shift register and dataB into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits); count=0; go to RUN.
- RUN, each cycle:
  - Shift {rem,quo} left by one.
  - If rem >= divisor, subtract the divisor and set quo[0]=1.
  - count++; after iteration WIDTH-1, go to DONE.
- DONE: Hi<=rem[WIDTH-1:0], Lo<=quo, dbz<=(divisor==0); next state IDLE.
- Latency:
  - t0 is start, then 32 RUN cycles; DONE is cycle t0+33.
  - Hi/Lo are valid from t0+34.
  - The test sequence (hold 33 cycles, +2, then MFHI) fits this latency.
- Divide by zero: no special path. The algorithm naturally gives Lo=all ones and Hi=dividend; dbz=1.
- While busy:
  - Signal and dataA/dataB changes are ignored; latched operands are used.
  - MFHI/MFLO return the previous Hi/Lo values.
- Reset mid-operation: the division is abandoned, goes to IDLE next cycle, Hi/Lo=0.
- Hi/Lo change only in DONE or on reset.

Optional Feature:
- Macro: HILO_DIVIDER_SIGNED_EN.
- When defined, Signal==26 (DIV) is also accepted, edge-qualified like DIVU.
- Signed operation:
  - Operands are converted to magnitudes at start, and the sign flags are latched.
  - In DONE, the quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives Lo=0x80000000, Hi=0.
  - Signed divide by zero gives Lo=all ones, Hi=dividend.
- When not defined, code 26 is ignored like any unknown code.

Decomposition:
- Shared package alu_pkg holds:
  - Function-code constants FN_DIVU=27, FN_DIV=26, FN_MFHI=16, FN_MFLO=18, FN_MULTU=25.
  - The state enum IDLE/RUN/DONE.
- One natural sub-module: div_step.
  - Combinational single iteration.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Instantiated once in the RUN datapath.

Test Plan:
- Division and readback: assert reset==0 for 1 cycle, then DIVU 100/7 held 33 cycles, +2 idle, then MFHI and MFLO. Expect Hi=2, Lo=14, dbz=0, busy high for exactly 33 cycles.
- Largest dividend: DIVU 4294967295/1. Expect Lo=4294967295, Hi=0. Then DIVU 3/10: Lo=0, Hi=3.
- Divide by zero: DIVU 5/0. Expect Lo=4294967295, Hi=5, dbz=1; next DIVU 9/3 clears dbz, Lo=3, Hi=0.
- Reset mid-operation: start DIVU 1000/3, drive reset=0 at t0+10. Expect busy=0 next cycle; MFHI=0, MFLO=0; a following DIVU 1000/3 gives Lo=333, Hi=1.
- Held Signal and operand change: hold Signal=27 for 80 cycles and change dataA to 50 at t0+5 (initial 81/9). Expect a single busy pulse of 33 cycles, Lo=9, Hi=0. Also, MFHI during busy returns the prior Hi.
- Signed division, with HILO_DIVIDER_SIGNED_EN: DIV -7/2 gives Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000/-1 gives Lo=0x80000000, Hi=0. Without the macro, Signal=26 leaves busy=0 and Hi/Lo unchanged.
